// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use and MDU-busy stalls,
// flush handling, MULT/DIV countdown FSM and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_is_mdu,
  input  logic             e_mem_read,
  input  logic [4:0]       e_rt,
  input  logic             mdu_start,
  input  logic             mdu_is_div,
  input  logic             flush_req,
  input  logic             stat_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MULT_LD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LD  = 8'(DIV_CYCLES - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]       ld_val;
  logic             load_use, mdu_haz, stall;

  assign load_use = e_mem_read && (e_rt != 5'd0) &&
                    ((d_use_rs && (d_rs == e_rt)) || (d_use_rt && (d_rt == e_rt)));
  assign mdu_busy = (state_q == BUSY);
  assign mdu_haz  = d_is_mdu && (mdu_busy || mdu_start);
  assign stall    = load_use || mdu_haz;

  // Reset forces the pipeline front end into a cleared, frozen state.
  assign pc_en     = reset && (flush_req || !stall);
  assign if_id_en  = reset && (flush_req || !stall);
  assign if_id_clr = !reset || flush_req;
  assign id_ex_clr = !reset || flush_req || stall;

  assign ld_val = mdu_is_div ? DIV_LD : MULT_LD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_start) begin
            state_q <= BUSY;
            cnt_q   <= ld_val;
            done_q  <= (ld_val == 8'd1);
          end else begin
            done_q  <= 1'b0;
          end
        end
        BUSY: begin
          // A second issue while counting is dropped; only the error is recorded.
          if (mdu_start) err_q <= 1'b1;
          cnt_q  <= cnt_q - 8'd1;
          done_q <= (cnt_q == 8'd2);
          if (cnt_q == 8'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdu_done = done_q;
  assign mdu_err  = err_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)
      stall_cnt_d = '0;
    else if (stall && !flush_req && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
